// File: rtl/xc_malu_seq_if.sv
// Request/response bundle for the shared MALU multiply sequencer.
// Two requesters present operations; one response port returns results.
interface xc_malu_seq_if;

  // Requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_rs1;
  logic [31:0] req0_rs2;

  // Requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_rs1;
  logic [31:0] req1_rs2;

  // Response
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;

  // Issue/writeback side: drives requests, consumes responses.
  modport master (
    output req0_valid, req0_op, req0_rs1, req0_rs2,
    output req1_valid, req1_op, req1_rs1, req1_rs2,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result
  );

  // Sequencer side.
  modport slave (
    input  req0_valid, req0_op, req0_rs1, req0_rs2,
    input  req1_valid, req1_op, req1_rs1, req1_rs2,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/xc_malu_seq.sv
// Iterative radix-2 multiply sequencer shared by two requesters.
// Round-robin arbitration in IDLE, 32 shift-and-add (or shift-and-xor)
// steps, then one result word held on a valid/ready response port.
module xc_malu_seq (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  output logic             busy,
  xc_malu_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // op encoding: bit 1 selects carry-less, bit 0 selects the high word
  localparam logic [4:0] LAST_STEP = 5'd31;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_mcand;
  logic [1:0]  r_op;
  logic        r_id;
  logic [4:0]  r_cnt;
  logic        r_prio;

  logic        w_idle;
  logic        w_done;
  logic        w_req0_ready;
  logic        w_req1_ready;
  logic        w_accept;
  logic        w_last;
  logic [31:0] w_addend;
  logic [32:0] w_sum;

  assign w_idle = (r_state == ST_IDLE);
  assign w_done = (r_state == ST_DONE);
  assign w_last = (r_cnt == LAST_STEP);

  // Round-robin grant: prio names the requester that wins a tie.
  // flush blocks acceptance so an abort can never race a new operation.
  assign w_req0_ready = w_idle & ~flush & bus.req0_valid
                      & (~bus.req1_valid | ~r_prio);
  assign w_req1_ready = w_idle & ~flush & bus.req1_valid
                      & (~bus.req0_valid |  r_prio);
  assign w_accept     = w_req0_ready | w_req1_ready;

  // One multiply step: add (integer) or xor (carry-less) the multiplicand
  // into the upper accumulator when the current multiplier bit is set.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_addend = '0;
    w_sum    = '0;
    if (r_acc_lo[0]) begin
      w_addend = r_mcand;
    end
    if (r_op[1]) begin
      w_sum = {1'b0, r_acc_hi ^ w_addend};
    end else begin
      w_sum = {1'b0, r_acc_hi} + {1'b0, w_addend};
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values, independent of block ordering.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides accept and the response handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_accept)      w_state_nxt = ST_STEP;
        ST_STEP: if (w_last)        w_state_nxt = ST_DONE;
        ST_DONE: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
        default:                    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic; response fields are forced to zero outside DONE so an
  // aborted or in-progress accumulator is never visible.
  always_comb begin
    bus.req0_ready = w_req0_ready;
    bus.req1_ready = w_req1_ready;
    bus.rsp_valid  = w_done;
    bus.rsp_id     = 1'b0;
    bus.rsp_result = '0;
    busy           = ~w_idle;
    if (w_done) begin
      bus.rsp_id     = r_id;
      bus.rsp_result = r_op[0] ? r_acc_hi : r_acc_lo;
    end
  end

  // Operand capture on accept and accumulator shift on each step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: datapath registers are reset as well so the response port
      // and all internal state come up at known zero values.
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_op     <= '0;
      r_id     <= 1'b0;
      r_cnt    <= '0;
      r_prio   <= 1'b0;
    end else if (w_accept) begin
      r_acc_hi <= '0;
      r_acc_lo <= w_req1_ready ? bus.req1_rs2 : bus.req0_rs2;
      r_mcand  <= w_req1_ready ? bus.req1_rs1 : bus.req0_rs1;
      r_op     <= w_req1_ready ? bus.req1_op  : bus.req0_op;
      r_id     <= w_req1_ready;
      r_cnt    <= '0;
      // The requester just served loses the next tie.
      r_prio   <= w_req0_ready;
    end else if ((r_state == ST_STEP) && !flush) begin
      // {acc_hi, acc_lo} <= {carry, sum, acc_lo[31:1]}; wraps cnt after 31
      r_acc_hi <= w_sum[32:1];
      r_acc_lo <= {w_sum[0], r_acc_lo[31:1]};
      r_cnt    <= r_cnt + 5'd1;
    end
  end

  // Arbitration invariants: grants are exclusive and never unrequested.
  a_ready_onehot : assert property (@(posedge clock) disable iff (!resetn)
    !(w_req0_ready && w_req1_ready));
  a_ready0_valid : assert property (@(posedge clock) disable iff (!resetn)
    w_req0_ready |-> bus.req0_valid);
  a_ready1_valid : assert property (@(posedge clock) disable iff (!resetn)
    w_req1_ready |-> bus.req1_valid);

endmodule

// File: tb/tb_xc_malu_seq.sv
// Directed self-checking bench for xc_malu_seq with hand-computed vectors.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_xc_malu_seq;

  logic clock;
  logic resetn;
  logic flush;
  logic busy;

  int n_checks;
  int n_errors;

  xc_malu_seq_if bus ();

  xc_malu_seq dut (
    .clock  (clock),
    .resetn (resetn),
    .flush  (flush),
    .busy   (busy),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin
      bus.req0_op = op; bus.req0_rs1 = a; bus.req0_rs2 = b;
    end else begin
      bus.req1_op = op; bus.req1_rs1 = a; bus.req1_rs2 = b;
    end
  endtask

  // Present one operation alone, confirm its grant, pass the accept edge,
  // then scramble the operands to prove they were captured at accept.
  task automatic start_op(input string tag, input int idx,
                          input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    set_req(idx, op, a, b);
    bus.req0_valid = (idx == 0);
    bus.req1_valid = (idx == 1);
    #1;
    check({tag, " grant"}, {62'd0, bus.req1_ready, bus.req0_ready},
          (idx == 0) ? 64'd1 : 64'd2);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    set_req(0, 2'b00, 32'hA5A5_0F0F, 32'h1234_5678);
    set_req(1, 2'b00, 32'h5A5A_F0F0, 32'h8765_4321);
  endtask

  // Count edges after the accept edge until rsp_valid, bounded.
  task automatic finish_op(input string tag, input logic [31:0] exp_res,
                           input logic exp_id);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 64) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd32);
    check({tag, " result"}, {32'd0, bus.rsp_result}, {32'd0, exp_res});
    check({tag, " id"}, {63'd0, bus.rsp_id}, {63'd0, exp_id});
    if (bus.rsp_ready) begin
      tick();
      check({tag, " drop"}, {63'd0, bus.rsp_valid}, 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  grants  [4];
    logic        ids     [4];
    logic [31:0] results [4];
    logic        bad;
    int          n_grant;
    int          n_rsp;
    int          budget;

    n_checks = 0;
    n_errors = 0;
    resetn = 1'b0;
    flush  = 1'b0;
    bus.rsp_ready = 1'b1;
    // Both requesters valid from reset: 3*5 from 0, 4*5 from 1.
    set_req(0, 2'b00, 32'd3, 32'd5);
    set_req(1, 2'b00, 32'd4, 32'd5);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("reset outputs", {30'd0, busy, bus.rsp_valid, bus.rsp_id, bus.rsp_result}, 64'd0);
    check("reset grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);

    // Round-robin: grants and response ids must alternate 0,1,0,1.
    resetn  = 1'b1;
    #1;
    n_grant = 0;
    n_rsp   = 0;
    budget  = 0;
    bad     = 1'b0;
    while (n_rsp < 4 && budget < 400) begin
      if (bus.req0_ready && bus.req1_ready) bad = 1'b1;
      if ((bus.req0_ready || bus.req1_ready) && n_grant < 4) begin
        grants[n_grant] = {bus.req1_ready, bus.req0_ready};
        n_grant++;
      end
      if (bus.rsp_valid) begin
        ids[n_rsp]     = bus.rsp_id;
        results[n_rsp] = bus.rsp_result;
        n_rsp++;
      end
      if (n_rsp < 4) tick();
      budget++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr responses", 64'(n_rsp), 64'd4);
    check("rr exclusive", {63'd0, bad}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr grant%0d", i), {62'd0, grants[i]},
            (i % 2 == 0) ? 64'd1 : 64'd2);
      check($sformatf("rr id%0d", i), {63'd0, ids[i]}, 64'(i % 2));
      check($sformatf("rr result%0d", i), {32'd0, results[i]},
            (i % 2 == 0) ? 64'd15 : 64'd20);
    end
    tick();
    check("rr idle", {63'd0, busy}, 64'd0);

    // Directed product vectors.
    start_op("mul_ff", 0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mul_ff", 32'h0000_0001, 1'b0);
    start_op("mulhu_ff", 0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("mulhu_ff", 32'hFFFF_FFFE, 1'b0);
    start_op("clmul_3", 1, 2'b10, 32'h3, 32'h3);
    finish_op("clmul_3", 32'h0000_0005, 1'b1);

    // Stall in DONE with rsp_ready low while requester 1 waits.
    bus.rsp_ready = 1'b0;
    start_op("stall", 0, 2'b00, 32'h10, 32'h10);
    finish_op("stall", 32'h0000_0100, 1'b0);
    set_req(1, 2'b01, 32'h8000_0000, 32'h2);
    bus.req1_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_result !== 32'h100 || bus.rsp_id !== 1'b0 ||
          bus.req0_ready || bus.req1_ready || !busy) bad = 1'b1;
    end
    check("stall stable", {63'd0, bad}, 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    check("stall release", {62'd0, bus.rsp_valid, bus.req1_ready}, 64'd1);
    tick();
    bus.req1_valid = 1'b0;
    set_req(1, 2'b00, 32'hFFFF_0000, 32'h0000_FFFF);
    finish_op("mulhu_8x2", 32'h0000_0001, 1'b1);

    // Flush at step 15; prio (now favouring requester 1) must survive.
    start_op("flush", 0, 2'b00, 32'd5, 32'd5);
    repeat (15) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush idle", {62'd0, busy, bus.rsp_valid}, 64'd0);
    set_req(0, 2'b00, 32'd9, 32'd9);
    set_req(1, 2'b00, 32'd7, 32'd6);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush blocks grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    flush = 1'b0;
    #1;
    check("flush prio kept", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd2);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    finish_op("mul_7x6", 32'd42, 1'b1);

    // Asynchronous reset mid-STEP; requester 0 must win afterwards.
    start_op("areset", 0, 2'b00, 32'd11, 32'd13);
    repeat (10) tick();
    set_req(0, 2'b11, 32'h8000_0000, 32'h8000_0000);
    set_req(1, 2'b00, 32'd2, 32'd2);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    resetn = 1'b0;
    #1;
    check("areset outputs", {30'd0, busy, bus.rsp_valid, bus.rsp_id, bus.rsp_result}, 64'd0);
    resetn = 1'b1;
    #1;
    check("areset grant", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    finish_op("clmulh_8x8", 32'h4000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
